pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer for the 7-bit program counter register of the pipelined CPU.
- Computes next PC and the fetch-stall signal. Arbitrates redirect sources: EX branch, ID jump, buffered pending redirect.
- Handshakes with a variable-latency instruction memory.
- Handles HALT/resume and ID-stage flush.
- Sits between hazard unit, ID/EX redirect logic and PC register (drives PCin/StallF).

Parameters:
- PC_W, 7, PC width; all PC arithmetic is modulo 2^PC_W.
- RESET_PC, 0, PC value driven on pc_next while in IDLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- pcf  in  PC_W  current PC from PC register
- hazard_stall  in  1  load-use stall request from hazard unit
- jump_d  in  1  jump resolved in ID
- jump_target_d  in  PC_W  jump target
- branch_e  in  1  taken branch resolved in EX
- branch_target_e  in  PC_W  branch target
- halt_d  in  1  HALT instruction decoded in ID
- resume  in  1  leave HALT
- imem_ready  in  1  instruction memory returned data this cycle
- imem_req  out  1  fetch request
- pc_next  out  PC_W  drives PC register PCin
- stall_f  out  1  drives PC register StallF
- flush_d  out  1  flush IF/ID register
- state_o  out  2  IDLE=0, FETCH=1, WAIT=2, HALT=3

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pend_v=0, pend_pc=0.
  - Outputs: imem_req=0, stall_f=1, flush_d=0, pc_next=RESET_PC.
- IDLE: lasts exactly one cycle after reset release, then FETCH. Outputs stay at reset values.
- FETCH/WAIT:
  - imem_req=1.
  - redir = branch_e | jump_d.
  - adv = imem_ready & (~hazard_stall | redir).
  - stall_f = ~adv.
- Next-PC priority (combinational): branch_target_e > jump_target_d > pend_pc (pend_v=1) > pcf+1.
  - pcf=127 gives pcf+1=0 (wrap, no carry out).
- flush_d = redir in FETCH/WAIT, same cycle, combinational. Forced 0 in IDLE/HALT.
- Pending redirect:
  - Capture: redir=1 with adv=0 latches the selected target into pend_pc and sets pend_v=1.
  - Overwrite: a later branch_e overwrites pend_pc. A later jump_d overwrites only when pend_v=0 or the pending entry came from a jump; an extra tag bit tracks the source.
  - Consume: pend_v clears on the first cycle with adv=1. If that cycle also has redir, the new target wins and pend_v clears.
- Transitions:
  - FETCH → WAIT when imem_ready=0.
  - WAIT → FETCH when imem_ready=1; that cycle advances per the adv rule.
  - FETCH → HALT when adv=1, halt_d=1 and redir=0. If branch_e or jump_d is asserted with halt_d, the redirect wins and halt_d is ignored.
  - HALT → FETCH when resume=1; the next fetch uses pcf+1, or pend_pc if pend_v=1.
- HALT outputs: imem_req=0, stall_f=1, flush_d=0. branch_e/jump_d are ignored in HALT.
- hazard_stall alone: stall_f=1, pc_next value don't-care, no state change.
- Reset mid-WAIT/HALT: immediate return to IDLE; pending redirect discarded.

Optional Feature:
- Macro: PC_FETCH_STALL_CNT_EN.
- Defined:
  - 16-bit counter stall_cycles (output port, width 16) increments every cycle with stall_f=1 in FETCH, WAIT or HALT.
  - Saturates at 16'hFFFF.
  - Synchronous clear input cnt_clr (1 bit) has priority over increment.
  - Counter resets to 0 on rst_n.
- Undefined: stall_cycles tied to 0, cnt_clr ignored, no counter flops.

Test Plan:
- Reset release, imem_ready=1 → one IDLE cycle with pc_next=0 and stall_f=1, then FETCH with stall_f=0 and pc_next=pcf+1.
- pcf=126 then 127, imem_ready=1 → pc_next=127, then 0 (wrap), flush_d=0 throughout.
- In WAIT (imem_ready=0), branch_e=1 with target 0x2A for 1 cycle; imem_ready=1 two cycles later → pend_v set; on the adv cycle pc_next=0x2A, stall_f=0; pend_v cleared afterwards.
- branch_e=1 (target 0x10) and jump_d=1 (target 0x20) same cycle, together with hazard_stall=1 → pc_next=0x10, stall_f=0, flush_d=1.
- halt_d=1 in FETCH with adv → HALT, imem_req=0, stall_f=1; resume=1 → FETCH, pc_next=pcf+1. halt_d together with branch_e → no HALT, redirect taken.
- With PC_FETCH_STALL_CNT_EN: 5 WAIT cycles → stall_cycles=5; cnt_clr=1 → 0 next cycle; forced saturation holds at 16'hFFFF.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer for the program counter.
// It computes the next PC and the fetch stall, and arbitrates between redirect
// sources: the EX branch, the ID jump, and a buffered pending redirect.
// It also handshakes with a variable-latency instruction memory and handles
// HALT/resume.
// Optional feature macro: PC_FETCH_STALL_CNT_EN adds a saturating 16-bit
// stall-cycle counter. When the macro is undefined, stall_cycles reads 0 and
// cnt_clr is ignored.

module pc_fetch_ctrl #(
    parameter int              PC_W     = 7,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pcf,
    input  logic            hazard_stall,
    input  logic            jump_d,
    input  logic [PC_W-1:0] jump_target_d,
    input  logic            branch_e,
    input  logic [PC_W-1:0] branch_target_e,
    input  logic            halt_d,
    input  logic            resume,
    input  logic            imem_ready,
    input  logic            cnt_clr,
    output logic            imem_req,
    output logic [PC_W-1:0] pc_next,
    output logic            stall_f,
    output logic            flush_d,
    output logic [1:0]      state_o,
    output logic [15:0]     stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_pend_v;    // a redirect is waiting for the next advance
    logic            r_pend_jmp;  // pending entry came from a jump (not a branch)
    logic [PC_W-1:0] r_pend_pc;

    logic            w_active;
    logic            w_redir;
    logic            w_adv;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_fall;
    logic [PC_W-1:0] w_pc_sel;

    // Redirects only count while fetching; HALT and IDLE ignore them.
    assign w_active  = (r_state == S_FETCH) || (r_state == S_WAIT);
    assign w_redir   = w_active & (branch_e | jump_d);
    // A redirect overrides a load-use stall because the stalled instruction is flushed.
    assign w_adv     = imem_ready & (~hazard_stall | w_redir);
    // Sequential PC wraps modulo 2^PC_W; the carry out is dropped.
    assign w_pc_inc  = pcf + PC_W'(1);
    assign w_pc_fall = r_pend_v ? r_pend_pc : w_pc_inc;
    assign state_o   = r_state;

    // Next-PC priority: EX branch, then ID jump, then the pending redirect, then PC+1.
    always_comb begin
        w_pc_sel = w_pc_fall;
        if (branch_e) begin
            w_pc_sel = branch_target_e;
        end else if (jump_d) begin
            w_pc_sel = jump_target_d;
        end
    end

    // Per-state drive of the PC register controls and the memory request.
    always_comb begin
        imem_req = 1'b0;
        stall_f  = 1'b1;
        flush_d  = 1'b0;
        pc_next  = RESET_PC;
        case (r_state)
            S_FETCH, S_WAIT: begin
                imem_req = 1'b1;
                stall_f  = ~w_adv;
                flush_d  = w_redir;
                pc_next  = w_pc_sel;
            end
            S_HALT: begin
                pc_next  = w_pc_fall;
            end
            default: begin
                pc_next  = RESET_PC;
            end
        endcase
    end

    // Sequencer state plus pending-redirect buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pend_v   <= 1'b0;
            r_pend_jmp <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH, S_WAIT: begin
                    // Any advance consumes the pending entry; a redirect in the
                    // same cycle has already been steered onto pc_next.
                    if (w_adv) begin
                        r_pend_v <= 1'b0;
                    end else if (branch_e) begin
                        r_pend_v   <= 1'b1;
                        r_pend_jmp <= 1'b0;
                        r_pend_pc  <= branch_target_e;
                    end else if (jump_d && (!r_pend_v || r_pend_jmp)) begin
                        // An older instruction's branch must not be displaced by a younger jump.
                        r_pend_v   <= 1'b1;
                        r_pend_jmp <= 1'b1;
                        r_pend_pc  <= jump_target_d;
                    end

                    if (r_state == S_FETCH) begin
                        if (!imem_ready) begin
                            r_state <= S_WAIT;
                        end else if (w_adv && halt_d && !w_redir) begin
                            r_state <= S_HALT;
                        end
                    end else if (imem_ready) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PC_FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of stalled fetch cycles; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (stall_f && (r_state != S_IDLE) && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign stall_cycles     = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model of the fetch sequencer.
// Build with +define+PC_FETCH_STALL_CNT_EN to exercise the stall counter.

module tb_pc_fetch_ctrl;

    localparam int PC_W = 7;
`ifdef PC_FETCH_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] pcf;
    logic            hazard_stall, jump_d, branch_e, halt_d, resume, imem_ready, cnt_clr;
    logic [PC_W-1:0] jump_target_d, branch_target_e;
    logic            imem_req, stall_f, flush_d;
    logic [PC_W-1:0] pc_next;
    logic [1:0]      state_o;
    logic [15:0]     stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model: 0=IDLE 1=FETCH 2=WAIT 3=HALT
    int  m_state;
    bit  m_pv;
    bit  m_pj;
    int  m_pp;
    int  m_cnt;
    bit  e_req, e_stall, e_flush, e_pc_care;
    int  e_pc;

    pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(7'd0)) dut (
        .clk(clk), .rst_n(rst_n), .pcf(pcf), .hazard_stall(hazard_stall),
        .jump_d(jump_d), .jump_target_d(jump_target_d), .branch_e(branch_e),
        .branch_target_e(branch_target_e), .halt_d(halt_d), .resume(resume),
        .imem_ready(imem_ready), .cnt_clr(cnt_clr), .imem_req(imem_req),
        .pc_next(pc_next), .stall_f(stall_f), .flush_d(flush_d),
        .state_o(state_o), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_pv = 0; m_pj = 0; m_pp = 0; m_cnt = 0;
    endtask

    // Expected outputs for the current model state and inputs.
    task automatic model_eval();
        bit fetching, redirect, advance;
        fetching  = (m_state == 1) || (m_state == 2);
        redirect  = fetching && (branch_e || jump_d);
        advance   = imem_ready && (!hazard_stall || redirect);
        e_req     = fetching;
        e_stall   = fetching ? !advance : 1'b1;
        e_flush   = redirect;
        e_pc_care = (m_state == 0) || !e_stall;
        if (m_state == 0)   e_pc = 0;
        else if (branch_e)  e_pc = int'(branch_target_e);
        else if (jump_d)    e_pc = int'(jump_target_d);
        else if (m_pv)      e_pc = m_pp;
        else                e_pc = (int'(pcf) + 1) % (1 << PC_W);
    endtask

    // Advance the model by one clock edge.
    task automatic model_step();
        bit redirect, advance;
        if (!rst_n) begin
            model_reset();
            return;
        end
        model_eval();
        redirect = branch_e || jump_d;
        advance  = imem_ready && (!hazard_stall || redirect);
        if (CNT_EN) begin
            if (cnt_clr) m_cnt = 0;
            else if (e_stall && m_state != 0 && m_cnt < 65535) m_cnt++;
        end
        case (m_state)
            0: m_state = 1;
            1, 2: begin
                if (advance) m_pv = 0;
                else if (branch_e) begin m_pv = 1; m_pj = 0; m_pp = int'(branch_target_e); end
                else if (jump_d && (!m_pv || m_pj)) begin m_pv = 1; m_pj = 1; m_pp = int'(jump_target_d); end
                if (m_state == 1) begin
                    if (!imem_ready) m_state = 2;
                    else if (advance && halt_d && !redirect) m_state = 3;
                end else if (imem_ready) m_state = 1;
            end
            default: if (resume) m_state = 1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        hazard_stall = 0; jump_d = 0; branch_e = 0; halt_d = 0; resume = 0; cnt_clr = 0;
        jump_target_d = '0; branch_target_e = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); imem_ready = 1; pcf = 7'd5;
        model_reset();
        repeat (2) tick();
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_o); end
        checks++; if ({imem_req, stall_f, flush_d} !== 3'b010) begin errors++; $display("FAIL rst_ctrl: req/stall/flush got %b want 010", {imem_req, stall_f, flush_d}); end
        checks++; if (pc_next !== 7'd0) begin errors++; $display("FAIL rst_pc: got %0h want 0", pc_next); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cycles); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (state_o !== 2'd0 || stall_f !== 1'b1 || pc_next !== 7'd0) begin errors++; $display("FAIL idle_cycle: state=%0d stall=%b pc=%0h want 0/1/0", state_o, stall_f, pc_next); end
        tick(); #1;
        checks++; if (state_o !== 2'd1 || stall_f !== 1'b0 || pc_next !== 7'd6) begin errors++; $display("FAIL first_fetch: state=%0d stall=%b pc=%0h want 1/0/6", state_o, stall_f, pc_next); end
        tick();
    endtask

    task automatic test_wrap();
        clear_inputs(); imem_ready = 1; pcf = 7'd126; #1;
        checks++; if (pc_next !== 7'd127 || flush_d !== 1'b0) begin errors++; $display("FAIL wrap_126: pc=%0h flush=%b want 7f/0", pc_next, flush_d); end
        tick(); pcf = 7'd127; #1;
        checks++; if (pc_next !== 7'd0 || flush_d !== 1'b0 || stall_f !== 1'b0) begin errors++; $display("FAIL wrap_127: pc=%0h flush=%b stall=%b want 0/0/0", pc_next, flush_d, stall_f); end
        tick();
    endtask

    task automatic test_pending_redirect();
        clear_inputs(); imem_ready = 0; pcf = 7'd3;
        tick();
        branch_e = 1; branch_target_e = 7'h2A; #1;
        checks++; if (state_o !== 2'd2 || flush_d !== 1'b1 || stall_f !== 1'b1) begin errors++; $display("FAIL wait_branch: state=%0d flush=%b stall=%b want 2/1/1", state_o, flush_d, stall_f); end
        tick();
        clear_inputs();
        tick();
        imem_ready = 1; pcf = 7'd5; #1;
        checks++; if (pc_next !== 7'h2A || stall_f !== 1'b0 || flush_d !== 1'b0) begin errors++; $display("FAIL pend_consume: pc=%0h stall=%b flush=%b want 2a/0/0", pc_next, stall_f, flush_d); end
        tick();
        pcf = 7'h2A; #1;
        checks++; if (pc_next !== 7'h2B || state_o !== 2'd1) begin errors++; $display("FAIL pend_cleared: pc=%0h state=%0d want 2b/1", pc_next, state_o); end
        tick();
    endtask

    // Two back-to-back redirects during WAIT, then an advance; which target survives.
    task automatic pend_seq(input bit first_br, input logic [PC_W-1:0] t1,
                            input bit second_br, input logic [PC_W-1:0] t2,
                            input logic [PC_W-1:0] want, input string name);
        clear_inputs(); imem_ready = 0; pcf = 7'd9;
        tick();
        if (first_br) begin branch_e = 1; branch_target_e = t1; end
        else begin jump_d = 1; jump_target_d = t1; end
        tick();
        clear_inputs();
        if (second_br) begin branch_e = 1; branch_target_e = t2; end
        else begin jump_d = 1; jump_target_d = t2; end
        tick();
        clear_inputs(); imem_ready = 1; #1;
        checks++; if (pc_next !== want || stall_f !== 1'b0) begin errors++; $display("FAIL %s: pc=%0h stall=%b want %0h/0", name, pc_next, stall_f, want); end
        tick();
    endtask

    task automatic test_pending_overwrite();
        pend_seq(1'b1, 7'h11, 1'b0, 7'h22, 7'h11, "jump_keeps_branch");
        pend_seq(1'b0, 7'h33, 1'b0, 7'h44, 7'h44, "jump_over_jump");
        pend_seq(1'b0, 7'h66, 1'b1, 7'h55, 7'h55, "branch_over_jump");
    endtask

    task automatic test_redirect_priority();
        clear_inputs(); imem_ready = 1; pcf = 7'd1;
        hazard_stall = 1; branch_e = 1; branch_target_e = 7'h10; jump_d = 1; jump_target_d = 7'h20; #1;
        checks++; if (pc_next !== 7'h10 || stall_f !== 1'b0 || flush_d !== 1'b1) begin errors++; $display("FAIL br_over_jmp: pc=%0h stall=%b flush=%b want 10/0/1", pc_next, stall_f, flush_d); end
        tick();
        branch_e = 0; #1;
        checks++; if (pc_next !== 7'h20 || stall_f !== 1'b0 || flush_d !== 1'b1) begin errors++; $display("FAIL jmp_over_hz: pc=%0h stall=%b flush=%b want 20/0/1", pc_next, stall_f, flush_d); end
        tick();
        jump_d = 0; #1;
        checks++; if (stall_f !== 1'b1 || flush_d !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL hazard_only: stall=%b flush=%b req=%b want 1/0/1", stall_f, flush_d, imem_req); end
        tick(); #1;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL hazard_state: got %0d want 1", state_o); end
        clear_inputs(); pcf = 7'd7; #1;
        checks++; if (pc_next !== 7'd8 || stall_f !== 1'b0) begin errors++; $display("FAIL hazard_release: pc=%0h stall=%b want 8/0", pc_next, stall_f); end
        tick();
    endtask

    task automatic test_halt();
        clear_inputs(); imem_ready = 1; pcf = 7'h30; halt_d = 1; #1;
        checks++; if (stall_f !== 1'b0 || flush_d !== 1'b0) begin errors++; $display("FAIL halt_adv: stall=%b flush=%b want 0/0", stall_f, flush_d); end
        tick();
        clear_inputs(); branch_e = 1; branch_target_e = 7'h7E; #1;
        checks++; if (state_o !== 2'd3 || imem_req !== 1'b0 || stall_f !== 1'b1 || flush_d !== 1'b0) begin errors++; $display("FAIL halt_out: state=%0d req=%b stall=%b flush=%b want 3/0/1/0", state_o, imem_req, stall_f, flush_d); end
        tick(); #1;
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL halt_hold: got %0d want 3", state_o); end
        clear_inputs(); resume = 1;
        tick();
        clear_inputs(); pcf = 7'h31; #1;
        checks++; if (state_o !== 2'd1 || pc_next !== 7'h32 || stall_f !== 1'b0) begin errors++; $display("FAIL resume: state=%0d pc=%0h stall=%b want 1/32/0", state_o, pc_next, stall_f); end
        tick();
        halt_d = 1; branch_e = 1; branch_target_e = 7'h40; #1;
        checks++; if (pc_next !== 7'h40 || flush_d !== 1'b1) begin errors++; $display("FAIL halt_vs_br: pc=%0h flush=%b want 40/1", pc_next, flush_d); end
        tick(); #1;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL halt_ignored: state=%0d want 1", state_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_midway();
        clear_inputs(); imem_ready = 0; pcf = 7'd2;
        tick();
        branch_e = 1; branch_target_e = 7'h5A;
        tick();
        clear_inputs(); rst_n = 0; model_reset(); #1;
        checks++; if (state_o !== 2'd0 || imem_req !== 1'b0 || stall_f !== 1'b1) begin errors++; $display("FAIL async_rst: state=%0d req=%b stall=%b want 0/0/1", state_o, imem_req, stall_f); end
        tick();
        rst_n = 1; imem_ready = 1; pcf = 7'd3;
        tick(); #1;
        checks++; if (pc_next !== 7'd4 || state_o !== 2'd1) begin errors++; $display("FAIL pend_discard: pc=%0h state=%0d want 4/1", pc_next, state_o); end
        tick();
    endtask

    task automatic test_stall_counter();
        clear_inputs(); imem_ready = 1; cnt_clr = 1;
        tick();
        cnt_clr = 0; imem_ready = 0;
        repeat (5) tick();
        #1;
        checks++; if (stall_cycles !== (CNT_EN ? 16'd5 : 16'd0)) begin errors++; $display("FAIL cnt_wait5: got %0d want %0d", stall_cycles, CNT_EN ? 5 : 0); end
        cnt_clr = 1;
        tick(); #1;
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL cnt_clr: got %0d want 0", stall_cycles); end
        cnt_clr = 0; imem_ready = 1;
        tick();
        if (CNT_EN) begin
            halt_d = 1;
            tick();
            halt_d = 0;
            repeat (65540) tick();
            #1;
            checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %0h want ffff", stall_cycles); end
            resume = 1;
            tick();
            clear_inputs(); cnt_clr = 1;
            tick();
            cnt_clr = 0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            pcf          = ($urandom_range(0, 7) == 0) ? 7'd127 : PC_W'($urandom);
            imem_ready   = ($urandom_range(0, 9) < 7);
            hazard_stall = ($urandom_range(0, 9) < 2);
            branch_e     = ($urandom_range(0, 9) == 0);
            jump_d       = ($urandom_range(0, 9) == 0);
            halt_d       = ($urandom_range(0, 19) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            cnt_clr      = ($urandom_range(0, 19) == 0);
            branch_target_e = PC_W'($urandom);
            jump_target_d   = PC_W'($urandom);
            if (!rst_n) model_reset();
            model_eval();
            #1;
            checks++; if (state_o !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state_o, m_state); end
            checks++; if ({imem_req, stall_f, flush_d} !== {e_req, e_stall, e_flush}) begin errors++; $display("FAIL rnd_ctrl[%0d]: req/stall/flush got %b want %b", i, {imem_req, stall_f, flush_d}, {e_req, e_stall, e_flush}); end
            if (e_pc_care) begin
                checks++; if (pc_next !== PC_W'(e_pc)) begin errors++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", i, pc_next, e_pc); end
            end
            checks++; if (stall_cycles !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cycles, m_cnt); end
            tick();
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_pending_redirect();
        test_pending_overwrite();
        test_redirect_priority();
        test_halt();
        test_reset_midway();
        test_stall_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
